// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32I-subset datapath: owns the PC and
// walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
module multicycle_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [31:0]      imm,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             ir_load,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             alusrc,
  output logic             regwrite,
  output logic             branch,
  output logic [1:0]       aluop,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BR, C_SYS, C_ILL
  } cls_t;

  typedef struct packed {
    logic       ir_load;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       busy;
    logic       halted;
  } ctl_t;

  function automatic cls_t classify(input logic [6:0] opc);
    cls_t c;
    case (opc)
      7'b0110011: c = C_R;
      7'b0010011: c = C_I;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BR;
      7'b1110011: c = C_SYS;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

  // Strobes depend only on the state being entered and the latched class,
  // so opcode/imm wiggles outside DECODE/EXECUTE never reach the outputs.
  function automatic ctl_t decode_ctl(input state_t st, input cls_t c);
    ctl_t v;
    logic is_mem;
    logic in_ex;
    v      = '0;
    is_mem = (c == C_LOAD) || (c == C_STORE);
    in_ex  = (st == S_EXECUTE) || (st == S_MEM) || (st == S_WRITEBACK);
    v.ir_load  = (st == S_FETCH);
    v.busy     = in_ex || (st == S_FETCH) || (st == S_DECODE);
    v.halted   = (st == S_HALT);
    v.alusrc   = in_ex && (is_mem || (c == C_I));
    v.aluop    = !in_ex ? 2'b00 : (is_mem ? 2'b00 : ((c == C_BR) ? 2'b01 : 2'b10));
    v.branch   = (st == S_EXECUTE) && (c == C_BR);
    v.memread  = (st == S_MEM) && (c == C_LOAD);
    v.memwrite = (st == S_MEM) && (c == C_STORE);
    v.regwrite = (st == S_WRITEBACK);
    v.memtoreg = (st == S_WRITEBACK) && (c == C_LOAD);
    return v;
  endfunction

  state_t            state_r, state_n;
  cls_t              op_r, op_n;
  logic [PC_W-1:0]   pc_r, pc_n;
  logic [CNT_W-1:0]  retired_r, retired_n;
  logic              illegal_r, illegal_n;
  ctl_t              ctl_r;
  logic              unused_imm_s;

  assign unused_imm_s = ^{imm[31:PC_W+2], imm[1:0]};

  // Next-state, PC and retire-count computation.
  always_comb begin
    state_n   = state_r;
    op_n      = op_r;
    pc_n      = pc_r;
    retired_n = retired_r;
    illegal_n = illegal_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_n = S_FETCH;
        else       state_n = S_IDLE;
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        op_n = classify(opcode);
        case (op_n)
          C_SYS:   state_n = S_HALT;
          C_ILL: begin
            state_n   = S_HALT;
            illegal_n = 1'b1;
          end
          default: state_n = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        case (op_r)
          C_LOAD, C_STORE: state_n = S_MEM;
          C_R, C_I:        state_n = S_WRITEBACK;
          C_BR: begin
            pc_n      = zero ? (pc_r + imm[PC_W+1:2]) : (pc_r + PC_W'(1));
            retired_n = retired_r + CNT_W'(1);
            state_n   = S_FETCH;
          end
          default: state_n = S_HALT;
        endcase
      end
      S_MEM: begin
        if (!mem_ready) begin
          state_n = S_MEM;
        end else if (op_r == C_LOAD) begin
          state_n = S_WRITEBACK;
        end else begin
          pc_n      = pc_r + PC_W'(1);
          retired_n = retired_r + CNT_W'(1);
          state_n   = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        pc_n      = pc_r + PC_W'(1);
        retired_n = retired_r + CNT_W'(1);
        state_n   = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          state_n   = S_FETCH;
          pc_n      = '0;
          retired_n = '0;
          illegal_n = 1'b0;
        end else begin
          state_n = S_HALT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, architectural registers and registered control strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      op_r      <= C_R;
      pc_r      <= '0;
      retired_r <= '0;
      illegal_r <= 1'b0;
      ctl_r     <= '0;
    end else begin
      state_r   <= state_n;
      op_r      <= op_n;
      pc_r      <= pc_n;
      retired_r <= retired_n;
      illegal_r <= illegal_n;
      ctl_r     <= decode_ctl(state_n, op_n);
    end
  end

  assign pc       = pc_r;
  assign retired  = retired_r;
  assign illegal  = illegal_r;
  assign ir_load  = ctl_r.ir_load;
  assign memread  = ctl_r.memread;
  assign memwrite = ctl_r.memwrite;
  assign memtoreg = ctl_r.memtoreg;
  assign alusrc   = ctl_r.alusrc;
  assign regwrite = ctl_r.regwrite;
  assign branch   = ctl_r.branch;
  assign aluop    = ctl_r.aluop;
  assign busy     = ctl_r.busy;
  assign halted   = ctl_r.halted;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed vector table, randomized program
// against a per-instruction phase-schedule model, and an async-reset abort.
module tb_multicycle_sequencer;
  localparam int PC_W = 10;
  localparam int CNT_W = 16;
  localparam int PC_MASK = (1 << PC_W) - 1;
  localparam int CNT_MASK = (1 << CNT_W) - 1;
  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PH = 5, PI = 6;
  localparam int CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3, CL_BR = 4, CL_SYS = 5, CL_ILL = 6;

  logic clk, rst_n, start, zero, mem_ready;
  logic [6:0] opcode;
  logic [31:0] imm;
  logic [PC_W-1:0] pc;
  logic ir_load, memread, memwrite, memtoreg, alusrc, regwrite, branch;
  logic [1:0] aluop;
  logic busy, halted, illegal;
  logic [CNT_W-1:0] retired;
  logic [10:0] ctl_s;

  int total = 0;
  int bad = 0;
  int m_pc, m_ret, busy_seen;
  logic m_ill, m_halt;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] imm;
    logic        z;
    int          stalls;
    int          cyc;
    int          pc;
    logic        halt;
    logic        ill;
  } vec_t;
  vec_t tbl[18];

  multicycle_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .imm(imm),
    .zero(zero), .mem_ready(mem_ready), .pc(pc), .ir_load(ir_load),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .alusrc(alusrc), .regwrite(regwrite), .branch(branch), .aluop(aluop),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  assign ctl_s = {ir_load, memread, memwrite, memtoreg, alusrc, regwrite, branch, aluop, busy, halted};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'h33:   return CL_R;
      7'h13:   return CL_I;
      7'h03:   return CL_LD;
      7'h23:   return CL_ST;
      7'h63:   return CL_BR;
      7'h73:   return CL_SYS;
      default: return CL_ILL;
    endcase
  endfunction

  // Expected strobes {ir_load,memread,memwrite,memtoreg,alusrc,regwrite,branch,aluop,busy,halted}
  function automatic logic [10:0] exp_ctl(input int ph, input int cls);
    logic is_mem, in_ex;
    logic [1:0] ao;
    is_mem = (cls == CL_LD) || (cls == CL_ST);
    in_ex  = (ph == PE) || (ph == PM) || (ph == PW);
    if (!in_ex) ao = 2'b00;
    else if (is_mem) ao = 2'b00;
    else if (cls == CL_BR) ao = 2'b01;
    else ao = 2'b10;
    return {ph == PF, (ph == PM) && (cls == CL_LD), (ph == PM) && (cls == CL_ST),
            (ph == PW) && (cls == CL_LD), in_ex && (is_mem || cls == CL_I),
            ph == PW, (ph == PE) && (cls == CL_BR), ao,
            in_ex || ph == PF || ph == PD, ph == PH};
  endfunction

  // One cycle of an instruction: check outputs, drive inputs, advance.
  task automatic cycle(input int ph, input int cls, input logic [6:0] op,
                       input logic [31:0] immv, input logic zv, input logic mr);
    chk($sformatf("ctl_ph%0d", ph), ctl_s, exp_ctl(ph, cls));
    chk("pc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("illegal", illegal, m_ill);
    if (busy === 1'b1) busy_seen++;
    opcode    = (ph == PD || ph == PE) ? op : 7'($urandom);
    imm       = (ph == PD || ph == PE) ? immv : $urandom;
    zero      = (ph == PE) ? zv : 1'($urandom);
    mem_ready = (ph == PM) ? mr : 1'($urandom);
    start     = 1'($urandom);
    step();
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [31:0] immv,
                           input logic zv, input int stalls);
    int cls;
    int s;
    cls = classify(op);
    busy_seen = 0;
    cycle(PF, cls, op, immv, zv, 1'b0);
    cycle(PD, cls, op, immv, zv, 1'b0);
    if (cls == CL_SYS || cls == CL_ILL) begin
      m_halt = 1'b1;
      m_ill  = (cls == CL_ILL);
      return;
    end
    cycle(PE, cls, op, immv, zv, 1'b0);
    if (cls == CL_LD || cls == CL_ST)
      for (int i = 0; i <= stalls; i++) cycle(PM, cls, op, immv, zv, i == stalls);
    if (cls == CL_R || cls == CL_I || cls == CL_LD)
      cycle(PW, cls, op, immv, zv, 1'b0);
    if (cls == CL_BR && zv) begin
      s = $signed(immv);
      s = s >>> 2;
      m_pc = (m_pc + s) & PC_MASK;
    end else begin
      m_pc = (m_pc + 1) & PC_MASK;
    end
    m_ret = (m_ret + 1) & CNT_MASK;
  endtask

  task automatic halt_and_restart();
    for (int i = 0; i < 2; i++) begin
      chk("halt_ctl", ctl_s, exp_ctl(PH, CL_R));
      chk("halt_pc", pc, m_pc);
      chk("halt_retired", retired, m_ret);
      chk("halt_illegal", illegal, m_ill);
      start = 1'b0;
      opcode = 7'($urandom);
      imm = $urandom;
      zero = 1'($urandom);
      mem_ready = 1'($urandom);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    m_pc = 0;
    m_ret = 0;
    m_ill = 1'b0;
    m_halt = 1'b0;
    chk("restart_pc", pc, 0);
    chk("restart_retired", retired, 0);
    chk("restart_illegal", illegal, 0);
    chk("restart_fetch", ctl_s, exp_ctl(PF, CL_R));
  endtask

  initial begin
    int r;
    logic [6:0] op;
    tbl[0]  = '{7'h33, 32'h0000_0ABC, 1'b0, 0, 4, 1,    1'b0, 1'b0};
    tbl[1]  = '{7'h03, 32'h0000_0004, 1'b0, 3, 8, 2,    1'b0, 1'b0};
    tbl[2]  = '{7'h13, 32'h0000_0ABC, 1'b1, 0, 4, 3,    1'b0, 1'b0};
    tbl[3]  = '{7'h23, 32'h0000_0008, 1'b0, 0, 4, 4,    1'b0, 1'b0};
    tbl[4]  = '{7'h23, 32'h0000_0008, 1'b1, 2, 6, 5,    1'b0, 1'b0};
    tbl[5]  = '{7'h63, 32'hFFFF_FFF8, 1'b1, 0, 3, 3,    1'b0, 1'b0};
    tbl[6]  = '{7'h13, 32'h0000_0001, 1'b0, 0, 4, 4,    1'b0, 1'b0};
    tbl[7]  = '{7'h33, 32'h0000_0000, 1'b1, 0, 4, 5,    1'b0, 1'b0};
    tbl[8]  = '{7'h63, 32'hFFFF_FFF8, 1'b0, 0, 3, 6,    1'b0, 1'b0};
    tbl[9]  = '{7'h63, 32'h0000_0013, 1'b1, 0, 3, 10,   1'b0, 1'b0};
    tbl[10] = '{7'h63, 32'hFFFF_FFD4, 1'b1, 0, 3, 1023, 1'b0, 1'b0};
    tbl[11] = '{7'h33, 32'h0000_0000, 1'b0, 0, 4, 0,    1'b0, 1'b0};
    tbl[12] = '{7'h03, 32'h0000_0000, 1'b0, 0, 5, 1,    1'b0, 1'b0};
    tbl[13] = '{7'h33, 32'h0000_0000, 1'b0, 0, 4, 2,    1'b0, 1'b0};
    tbl[14] = '{7'h7F, 32'h0000_0000, 1'b0, 0, 2, 2,    1'b1, 1'b1};
    tbl[15] = '{7'h63, 32'hFFFF_FFFC, 1'b1, 0, 3, 1023, 1'b0, 1'b0};
    tbl[16] = '{7'h73, 32'h0000_0000, 1'b0, 0, 2, 1023, 1'b1, 1'b0};
    tbl[17] = '{7'h03, 32'h0000_0010, 1'b0, 1, 6, 1,    1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; opcode = 7'h00; imm = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    m_pc = 0; m_ret = 0; m_ill = 1'b0; m_halt = 1'b0; busy_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", ctl_s, exp_ctl(PI, CL_R));
    chk("reset_pc", pc, 0);
    chk("reset_retired", retired, 0);
    chk("reset_illegal", illegal, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("idle_ctl", ctl_s, exp_ctl(PI, CL_R));
      opcode = 7'($urandom); imm = $urandom; mem_ready = 1'($urandom);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;

    for (int k = 0; k < 18; k++) begin
      run_instr(tbl[k].op, tbl[k].imm, tbl[k].z, tbl[k].stalls);
      chk($sformatf("vec%0d_cycles", k), busy_seen, tbl[k].cyc);
      chk($sformatf("vec%0d_pc", k), pc, tbl[k].pc);
      chk($sformatf("vec%0d_halted", k), halted, tbl[k].halt);
      if (tbl[k].halt) begin
        chk($sformatf("vec%0d_illegal", k), illegal, tbl[k].ill);
        halt_and_restart();
      end
    end

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      if (r < 4) op = 7'h33;
      else if (r < 8) op = 7'h13;
      else if (r < 12) op = 7'h03;
      else if (r < 16) op = 7'h23;
      else if (r < 19) op = 7'h63;
      else if ($urandom_range(0, 1) == 0) op = 7'h73;
      else op = 7'($urandom);
      run_instr(op, $urandom, 1'($urandom), $urandom_range(0, 3));
      if (m_halt) halt_and_restart();
    end

    // Reset while a store is stalled in MEM.
    cycle(PF, CL_ST, 7'h23, 32'h0, 1'b0, 1'b0);
    cycle(PD, CL_ST, 7'h23, 32'h0, 1'b0, 1'b0);
    cycle(PE, CL_ST, 7'h23, 32'h0, 1'b0, 1'b0);
    cycle(PM, CL_ST, 7'h23, 32'h0, 1'b0, 1'b0);
    cycle(PM, CL_ST, 7'h23, 32'h0, 1'b0, 1'b0);
    chk("abort_memwrite_before", memwrite, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", ctl_s, exp_ctl(PI, CL_R));
    chk("abort_pc", pc, 0);
    chk("abort_retired", retired, 0);
    chk("abort_illegal", illegal, 0);
    step();
    step();
    rst_n = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    step();
    chk("abort_idle_ctl", ctl_s, exp_ctl(PI, CL_R));
    chk("abort_idle_pc", pc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32I-subset datapath (instruction memory, register file, ALU, data memory, immediate generator, 2:1 muxes). Owns the program counter and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, emitting the datapath control strobes per phase. Also stalls on a data-memory ready handshake and halts on system or illegal opcodes. Replaces the manual PC stepping used to exercise the datapath until now.

## Interface
Parameters:
- PC_W, 10, PC width in instruction-word units; matches instruction/data memory depth.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution from IDLE, or restart from HALT.
- opcode  in  7  instruction[6:0] from instruction memory.
- imm  in  32  immediate-generator output (B-type byte offset for branches).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data memory completes the access this cycle.
- pc  out  PC_W  current instruction address (word index).
- ir_load  out  1  instruction register capture strobe.
- memread, memwrite, memtoreg, alusrc, regwrite, branch  out  1 each  datapath controls.
- aluop  out  2  00 add (load/store), 01 subtract (branch), 10 funct-decoded (R-type and I-ALU).
- busy  out  1  high in any state other than IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: HALT entered via unsupported opcode.
- retired  out  CNT_W  instructions completed since reset or restart.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- IDLE: start=1 -> FETCH; else stay.
- FETCH: ir_load=1 for one cycle -> DECODE.
- DECODE: opcode captured into internal op register at end of cycle. Classes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH (BEQ semantics), 1110011 SYS. SYS -> HALT; any other opcode -> HALT with illegal<=1; else -> EXECUTE.
- EXECUTE: aluop/alusrc driven by class. LOAD/STORE -> MEM; R/I-ALU -> WRITEBACK; BRANCH: branch=1, zero sampled at end of cycle, pc updated, retired++, -> FETCH.
- MEM: memread (LOAD) or memwrite (STORE) held high while mem_ready=0. On the mem_ready=1 cycle: LOAD -> WRITEBACK; STORE: pc+1, retired++, -> FETCH.
- WRITEBACK: regwrite=1 for exactly one cycle; memtoreg=1 for LOAD only; pc+1, retired++ -> FETCH.
- HALT: pc frozen; start=1 -> FETCH with pc<=0, retired<=0, illegal<=0.
- Control outputs are decoded only from state and the latched op register. opcode/imm changes outside DECODE/EXECUTE must not affect them.
- alusrc=1 for I-ALU, LOAD, STORE in EXECUTE/MEM/WRITEBACK; 0 otherwise. aluop held constant from EXECUTE through the instruction's last state. All strobes are 0 in IDLE, FETCH, DECODE, HALT.
- Branch arithmetic: taken (zero=1) pc <= pc + imm[PC_W+1:2] modulo 2^PC_W; not taken pc <= pc+1. imm[1:0] ignored.
- pc increment wraps 2^PC_W-1 -> 0. retired wraps at 2^CNT_W.

## Timing
- Reset (async, any state, mid-access included): state IDLE, pc=0, retired=0, illegal=0, all strobes 0, busy=0, halted=0. The memory access in flight is abandoned.
- Cycles per instruction (mem_ready immediately high): BRANCH 3, R/I-ALU 4, STORE 4, LOAD 5. Each mem_ready=0 cycle in MEM adds one cycle.
- pc and retired update on the clock edge leaving the final state of an instruction. The new pc is visible in the following FETCH.
- start is ignored while busy=1. start in the same cycle as reset release is ignored (reset dominates).
- mem_ready is ignored outside MEM.

## Test plan
- Reset then start, program R-type at pc0 -> FETCH..WRITEBACK in 4 cycles, regwrite pulse 1 cycle, pc=1, retired=1.
- LOAD with mem_ready low 3 cycles -> memread high 4 cycles, memtoreg=1 in WRITEBACK, 8 cycles total, pc+1.
- BEQ at pc=5, imm=-8, zero=1 -> pc=3 after 3 cycles. Same with zero=0 -> pc=6. BEQ at pc=0, imm=-4 -> pc=1023.
- Opcode 1111111 at pc=2 -> HALT, illegal=1, halted=1, pc=2. start -> pc=0, illegal=0, retired=0.
- rst_n low during STORE MEM stall -> memwrite drops immediately (async), all outputs at reset values, IDLE.
- Opcode/imm toggled randomly outside DECODE/EXECUTE -> no change on any control output.
